// File: rtl/decode_cycle_if.sv
// Fetch-to-decode inputs, writeback port and ID/EX outputs of the decode stage.
// DECODE_ILLEGAL_DETECT_EN adds the IllegalE output.
interface decode_cycle_if #(
    parameter int XLEN = 32
);
    logic [31:0]     InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic [2:0]      Funct3E;
`ifdef DECODE_ILLEGAL_DETECT_EN
    logic            IllegalE;
`endif

    modport master (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
`ifdef DECODE_ILLEGAL_DETECT_EN
        output IllegalE,
`endif
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
               ALUSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, Funct3E
    );

    modport slave (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
`ifdef DECODE_ILLEGAL_DETECT_EN
        input  IllegalE,
`endif
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
               ALUSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE, Funct3E
    );
endinterface

// File: rtl/decode_cycle.sv
// RV32I decode stage: register file with write-through bypass, decoders, immediate
// extender and the ID/EX pipeline register. DECODE_ILLEGAL_DETECT_EN enables IllegalE.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_cycle_if.master bus
);
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;

    typedef struct packed {
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
`ifdef DECODE_ILLEGAL_DETECT_EN
        logic            illegal;
`endif
    } idex_t;

    function automatic logic signed [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                          input imm_src_t   src);
        logic signed [XLEN-1:0] v;
        case (src)
            IMM_I:   v = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   v = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   v = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
            default: v = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
        endcase
        return v;
    endfunction

    // A same-cycle writeback to the indexed register wins over the stored copy.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0]      idx,
                                                  input logic [XLEN-1:0] stored,
                                                  input logic            wen,
                                                  input logic [4:0]      waddr,
                                                  input logic [XLEN-1:0] wdata);
        if (idx == 5'd0)
            return '0;
        else if (wen && waddr == idx)
            return wdata;
        else
            return stored;
    endfunction

    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (bus.RegWriteW && bus.RdW != 5'd0) begin
            rf[bus.RdW] <= bus.ResultW;
        end
    end

    logic [6:0]      opcode_p0;
    logic [2:0]      funct3_p0;
    logic [6:0]      funct7_p0;
    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic [1:0]      alu_op_p0;
    imm_src_t        imm_src_p0;
    logic            imm_en_p0;
    logic            known_p0;
    logic signed [XLEN-1:0] imm_p0;
    idex_t           idex_p0;
    idex_t           idex_p1;

    assign opcode_p0 = bus.InstrD[6:0];
    assign funct3_p0 = bus.InstrD[14:12];
    assign funct7_p0 = bus.InstrD[31:25];
    assign rs1_p0    = bus.InstrD[19:15];
    assign rs2_p0    = bus.InstrD[24:20];

    always_comb begin
        idex_p0    = '0;
        alu_op_p0  = 2'b00;
        imm_src_p0 = IMM_I;
        imm_en_p0  = 1'b1;
        known_p0   = 1'b1;

        case (opcode_p0)
            OP_LW: begin
                idex_p0.reg_write  = 1'b1;
                idex_p0.alu_src    = 1'b1;
                idex_p0.result_src = 2'b01;
            end
            OP_SW: begin
                idex_p0.mem_write = 1'b1;
                idex_p0.alu_src   = 1'b1;
                imm_src_p0        = IMM_S;
            end
            OP_R: begin
                idex_p0.reg_write = 1'b1;
                alu_op_p0         = 2'b10;
            end
            OP_I: begin
                idex_p0.reg_write = 1'b1;
                idex_p0.alu_src   = 1'b1;
                alu_op_p0         = 2'b10;
            end
            OP_BEQ: begin
                idex_p0.branch = 1'b1;
                imm_src_p0     = IMM_B;
                alu_op_p0      = 2'b01;
            end
            OP_JAL: begin
                idex_p0.reg_write  = 1'b1;
                idex_p0.jump       = 1'b1;
                idex_p0.result_src = 2'b10;
                imm_src_p0         = IMM_J;
            end
            default: begin
                imm_en_p0 = 1'b0;
                known_p0  = 1'b0;
            end
        endcase

        // funct7[5] selects sub only for register-register ops; addi keeps add.
        case (alu_op_p0)
            2'b01:   idex_p0.alu_control = ALU_SUB;
            2'b10: begin
                case (funct3_p0)
                    3'b000:  idex_p0.alu_control = (opcode_p0 == OP_R && funct7_p0[5])
                                                   ? ALU_SUB : ALU_ADD;
                    3'b010:  idex_p0.alu_control = ALU_SLT;
                    3'b110:  idex_p0.alu_control = ALU_OR;
                    3'b111:  idex_p0.alu_control = ALU_AND;
                    default: idex_p0.alu_control = ALU_ADD;
                endcase
            end
            default: idex_p0.alu_control = ALU_ADD;
        endcase

        imm_p0           = imm_en_p0 ? imm_extend(bus.InstrD, imm_src_p0) : '0;
        idex_p0.imm_ext  = imm_p0;
        idex_p0.rd1      = read_port(rs1_p0, rf[rs1_p0], bus.RegWriteW, bus.RdW, bus.ResultW);
        idex_p0.rd2      = read_port(rs2_p0, rf[rs2_p0], bus.RegWriteW, bus.RdW, bus.ResultW);
        idex_p0.pc       = bus.PCD;
        idex_p0.pc_plus4 = bus.PCPlus4D;
        idex_p0.rs1      = rs1_p0;
        idex_p0.rs2      = rs2_p0;
        idex_p0.rd       = bus.InstrD[11:7];
        idex_p0.funct3   = funct3_p0;
`ifdef DECODE_ILLEGAL_DETECT_EN
        idex_p0.illegal  = !known_p0
                         || (opcode_p0 == OP_R && funct7_p0 != 7'b0000000
                                               && funct7_p0 != 7'b0100000)
                         || bus.InstrD[1:0] != 2'b11;
`endif
    end

    // ---- ID/EX boundary: a flush turns the slot into an all-zero bubble ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idex_p1 <= '0;
        else if (bus.FlushE)
            idex_p1 <= '0;
        else
            idex_p1 <= idex_p0;
    end

    assign bus.RegWriteE   = idex_p1.reg_write;
    assign bus.ResultSrcE  = idex_p1.result_src;
    assign bus.MemWriteE   = idex_p1.mem_write;
    assign bus.JumpE       = idex_p1.jump;
    assign bus.BranchE     = idex_p1.branch;
    assign bus.ALUControlE = idex_p1.alu_control;
    assign bus.ALUSrcE     = idex_p1.alu_src;
    assign bus.RD1E        = idex_p1.rd1;
    assign bus.RD2E        = idex_p1.rd2;
    assign bus.ImmExtE     = idex_p1.imm_ext;
    assign bus.PCE         = idex_p1.pc;
    assign bus.PCPlus4E    = idex_p1.pc_plus4;
    assign bus.Rs1E        = idex_p1.rs1;
    assign bus.Rs2E        = idex_p1.rs2;
    assign bus.RdE         = idex_p1.rd;
    assign bus.Funct3E     = idex_p1.funct3;
`ifdef DECODE_ILLEGAL_DETECT_EN
    assign bus.IllegalE    = idex_p1.illegal;
`endif
endmodule
